// File: rtl/scan_mux_pkg.sv
// Shared types for the registered scan multiplexer.
// Mode encodings and one-shot FSM states.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT  = 2'b00,
        MODE_SCAN    = 2'b01,
        MODE_HOLD    = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        OS_IDLE = 2'b00,
        OS_RUN  = 2'b01,
        OS_DONE = 2'b10
    } os_state_t;

endpackage

// File: rtl/scan_mux_sel_counter.sv
// Select counter: clear, clamped load, step with wrap at INPUTS-1.
// The wrap pulse is registered so it lines up with the counter reading 0.
module scan_mux_sel_counter
    import scan_mux_pkg::*;
#(
    parameter int  INPUTS = 4,
    localparam int SEL_W  = $clog2(INPUTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [SEL_W-1:0] val_i,
    output logic [SEL_W-1:0] cnt_o,
    output logic             wrap_o
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(INPUTS - 1);

    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             last;

    assign last = (cnt_q == LAST);

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            // Out-of-range selects fold to input 0
            cnt_d = (int'(val_i) < INPUTS) ? val_i : '0;
        end else if (step_i) begin
            cnt_d  = last ? '0 : cnt_q + SEL_W'(1);
            wrap_d = last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/scan_mux_reg.sv
// Registered N-channel M-input selector with direct, scan,
// hold and one-shot scan modes sharing one select counter.
module scan_mux_reg
    import scan_mux_pkg::*;
#(
    parameter int  CHANNELS = 2,
    parameter int  INPUTS   = 4,
    localparam int SEL_W    = $clog2(INPUTS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 mode,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       load_sel,
    input  logic                       advance,
    input  logic [CHANNELS-1:0]        enable_n,
    input  logic [CHANNELS*INPUTS-1:0] data,
    output logic [CHANNELS-1:0]        y,
    output logic [SEL_W-1:0]           sel_q,
    output logic                       valid,
    output logic                       wrap,
    output logic                       done
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(INPUTS - 1);

    os_state_t             state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic [CHANNELS-1:0]   y_q, y_d;
    logic [SEL_W-1:0]      cnt, sel_cl, idx;
    logic                  smp, clr, ld, stp;

    assign sel_cl = (int'(sel) < INPUTS) ? sel : '0;

    always_comb begin
        state_d = OS_IDLE;
        valid_d = 1'b0;
        done_d  = 1'b0;
        smp     = 1'b0;
        idx     = '0;
        clr     = 1'b0;
        ld      = 1'b0;
        stp     = 1'b0;
        unique case (mode_t'(mode))
            MODE_DIRECT: begin
                smp     = 1'b1;
                idx     = sel_cl;
                ld      = 1'b1;
                valid_d = 1'b1;
            end
            MODE_SCAN: begin
                smp     = 1'b1;
                idx     = cnt;
                ld      = load_sel;
                stp     = advance & ~load_sel;
                valid_d = 1'b1;
            end
            MODE_HOLD: begin
            end
            MODE_ONESHOT: begin
                unique case (state_q)
                    OS_IDLE: begin
                        if (advance) begin
                            state_d = OS_RUN;
                            clr     = 1'b1;
                        end
                    end
                    OS_RUN: begin
                        smp     = 1'b1;
                        idx     = cnt;
                        valid_d = 1'b1;
                        // Park on the last input once the pass finishes
                        if (cnt == LAST) begin
                            state_d = OS_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = OS_RUN;
                            stp     = 1'b1;
                        end
                    end
                    OS_DONE: begin
                        state_d = OS_DONE;
                        done_d  = 1'b1;
                        if (advance) begin
                            state_d = OS_RUN;
                            clr     = 1'b1;
                            done_d  = 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
            end
        endcase
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [INPUTS-1:0] row;
        assign row    = data[c*INPUTS +: INPUTS];
        assign y_d[c] = enable_n[c] ? 1'b0 : row[idx];
    end

    scan_mux_sel_counter #(
        .INPUTS (INPUTS)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (clr),
        .load_i (ld),
        .step_i (stp),
        .val_i  (sel),
        .cnt_o  (cnt),
        .wrap_o (wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OS_IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            if (smp) y_q <= y_d;
        end
    end

    assign y     = y_q;
    assign sel_q = cnt;
    assign valid = valid_q;
    assign done  = done_q;

endmodule

// File: tb/tb_scan_mux_reg.sv
// Bench for scan_mux_reg: default 2x4 and a 4x3 instance,
// directed scenarios plus random stimulus against a behavioural model.
module tb_scan_mux_reg;

    typedef struct {
        int         sel_q;
        logic [3:0] y;
        logic       valid;
        logic       wrap;
        logic       done;
        logic       running;
    } model_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: CHANNELS=2, INPUTS=4
    logic       ra, a_ld, a_adv, a_valid, a_wrap, a_done;
    logic [1:0] a_mode, a_sel, a_en, a_y, a_selq;
    logic [7:0] a_data;

    // Instance B: CHANNELS=4, INPUTS=3
    logic        rb, b_ld, b_adv, b_valid, b_wrap, b_done;
    logic [1:0]  b_mode, b_sel, b_selq;
    logic [3:0]  b_en, b_y;
    logic [11:0] b_data;

    model_t ma, mb;

    scan_mux_reg #(.CHANNELS(2), .INPUTS(4)) u_a (
        .clk(clk), .reset(ra), .mode(a_mode), .sel(a_sel),
        .load_sel(a_ld), .advance(a_adv), .enable_n(a_en),
        .data(a_data), .y(a_y), .sel_q(a_selq), .valid(a_valid),
        .wrap(a_wrap), .done(a_done)
    );

    scan_mux_reg #(.CHANNELS(4), .INPUTS(3)) u_b (
        .clk(clk), .reset(rb), .mode(b_mode), .sel(b_sel),
        .load_sel(b_ld), .advance(b_adv), .enable_n(b_en),
        .data(b_data), .y(b_y), .sel_q(b_selq), .valid(b_valid),
        .wrap(b_wrap), .done(b_done)
    );

    // One clock of the selector, straight from the written rules
    function automatic model_t nxt(model_t m, int ni, int nc,
                                   logic rst, logic [1:0] md, int sel,
                                   logic ld, logic adv, logic [3:0] en,
                                   logic [15:0] d);
        model_t r = m;
        int s = (sel < ni) ? sel : 0;
        int k = -1;
        r.wrap  = 1'b0;
        r.valid = 1'b0;
        if (rst) begin
            r = '{0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
            return r;
        end
        if (md != 2'd3) begin
            r.done    = 1'b0;
            r.running = 1'b0;
        end
        case (md)
            2'd0: begin
                k = s;
                r.sel_q = s;
                r.valid = 1'b1;
            end
            2'd1: begin
                k = m.sel_q;
                r.valid = 1'b1;
                if (ld) r.sel_q = s;
                else if (adv) begin
                    if (m.sel_q == ni - 1) begin
                        r.sel_q = 0;
                        r.wrap  = 1'b1;
                    end else r.sel_q = m.sel_q + 1;
                end
            end
            2'd2: ;
            default: begin
                if (m.running) begin
                    k = m.sel_q;
                    r.valid = 1'b1;
                    if (m.sel_q == ni - 1) begin
                        r.running = 1'b0;
                        r.done    = 1'b1;
                    end else r.sel_q = m.sel_q + 1;
                end else if (adv) begin
                    r.running = 1'b1;
                    r.sel_q   = 0;
                    r.done    = 1'b0;
                end
            end
        endcase
        if (k >= 0)
            for (int c = 0; c < nc; c++)
                r.y[c] = en[c] ? 1'b0 : d[c*ni + k];
        return r;
    endfunction

    function automatic logic [8:0] exp_vec(model_t m);
        return {m.y, 2'(m.sel_q), m.valid, m.wrap, m.done};
    endfunction

    function automatic logic [8:0] got_a();
        return {2'b00, a_y, a_selq, a_valid, a_wrap, a_done};
    endfunction

    function automatic logic [8:0] got_b();
        return {b_y, b_selq, b_valid, b_wrap, b_done};
    endfunction

    task automatic cyc();
        ma = nxt(ma, 4, 2, ra, a_mode, int'(a_sel), a_ld, a_adv,
                 {2'b00, a_en}, {8'h00, a_data});
        mb = nxt(mb, 3, 4, rb, b_mode, int'(b_sel), b_ld, b_adv,
                 b_en, {4'h0, b_data});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ra = 1'b1; rb = 1'b1;
        a_mode = 2'd1; a_sel = 2'd3; a_ld = 1'b1; a_adv = 1'b1;
        a_en = 2'b00; a_data = 8'hFF;
        b_mode = 2'd0; b_sel = 2'd2; b_ld = 1'b0; b_adv = 1'b1;
        b_en = 4'h0; b_data = 12'hFFF;
        cyc();
        cyc();
        checks++;
        if (got_a() !== 9'h000) begin
            failures++;
            $display("FAIL reset_a got=%h exp=%h", got_a(), 9'h000);
        end
        checks++;
        if (got_b() !== 9'h000) begin
            failures++;
            $display("FAIL reset_b got=%h exp=%h", got_b(), 9'h000);
        end
        ra = 1'b0; rb = 1'b0;
        b_mode = 2'd2;
    endtask

    task automatic test_direct();
        a_mode = 2'd0; a_en = 2'b00; a_ld = 1'b0; a_adv = 1'b0;
        a_data = 8'hA5;
        for (int s = 0; s < 4; s++) begin
            a_sel = 2'(s);
            cyc();
            checks++;
            if ({a_y, a_selq, a_valid} !==
                {a_data[4+s], a_data[s], 2'(s), 1'b1}) begin
                failures++;
                $display("FAIL direct_sel%0d got=%b/%0d/%b exp=%b",
                         s, a_y, a_selq, a_valid,
                         {a_data[4+s], a_data[s]});
            end
            checks++;
            if (got_a() !== exp_vec(ma)) begin
                failures++;
                $display("FAIL direct_model got=%h exp=%h",
                         got_a(), exp_vec(ma));
            end
        end
    endtask

    task automatic test_scan();
        int seq [6] = '{1, 2, 3, 0, 1, 2};
        a_mode = 2'd0; a_sel = 2'd0;
        cyc();
        a_mode = 2'd1; a_adv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_data = 8'($urandom);
            cyc();
            checks++;
            if ({a_selq, a_wrap} !== {2'(seq[i]), i == 3}) begin
                failures++;
                $display("FAIL scan_step%0d got=%0d/%b exp=%0d/%b",
                         i, a_selq, a_wrap, seq[i], i == 3);
            end
            checks++;
            if (got_a() !== exp_vec(ma)) begin
                failures++;
                $display("FAIL scan_model got=%h exp=%h",
                         got_a(), exp_vec(ma));
            end
        end
        a_ld = 1'b1; a_sel = 2'd2;
        cyc();
        checks++;
        if (a_selq !== 2'd2 || a_wrap !== 1'b0) begin
            failures++;
            $display("FAIL scan_load got=%0d exp=2", a_selq);
        end
        a_ld = 1'b0; a_adv = 1'b0;
    endtask

    task automatic test_oneshot();
        a_mode = 2'd3; a_adv = 1'b1; a_data = 8'h6C;
        cyc();
        checks++;
        if ({a_selq, a_valid, a_done} !== 4'b0000) begin
            failures++;
            $display("FAIL os_start got=%0d/%b/%b exp=0/0/0",
                     a_selq, a_valid, a_done);
        end
        a_adv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++;
            if ({a_y, a_valid, a_done} !==
                {a_data[4+k], a_data[k], 1'b1, k == 3}) begin
                failures++;
                $display("FAIL os_sample%0d got=%b/%b/%b exp=%b/1/%b",
                         k, a_y, a_valid, a_done,
                         {a_data[4+k], a_data[k]}, k == 3);
            end
        end
        cyc();
        checks++;
        if ({a_y, a_selq, a_valid, a_done} !==
            {a_data[7], a_data[3], 2'd3, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL os_done got=%b/%0d/%b/%b exp=%b/3/0/1",
                     a_y, a_selq, a_valid, a_done,
                     {a_data[7], a_data[3]});
        end
        a_adv = 1'b1;
        cyc();
        checks++;
        if ({a_selq, a_valid, a_done} !== 4'b0000) begin
            failures++;
            $display("FAIL os_restart got=%0d/%b/%b exp=0/0/0",
                     a_selq, a_valid, a_done);
        end
        a_adv = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++;
            if (got_a() !== exp_vec(ma)) begin
                failures++;
                $display("FAIL os_model got=%h exp=%h",
                         got_a(), exp_vec(ma));
            end
        end
    endtask

    task automatic test_hold();
        logic [1:0] yh;
        a_mode = 2'd1; a_ld = 1'b1; a_sel = 2'd3; a_data = 8'h88;
        cyc();
        a_ld = 1'b0;
        cyc();
        yh = a_y;
        checks++;
        if (yh !== 2'b11) begin
            failures++;
            $display("FAIL hold_setup got=%b exp=11", yh);
        end
        a_mode = 2'd2; a_adv = 1'b1; a_ld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data = 8'($urandom);
            cyc();
            checks++;
            if ({a_y, a_selq, a_valid, a_wrap} !==
                {yh, 2'd3, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL hold got=%b/%0d/%b exp=%b/3/0",
                         a_y, a_selq, a_valid, yh);
            end
        end
        a_mode = 2'd0; a_adv = 1'b0; a_ld = 1'b0;
        a_en = 2'b10; a_data = 8'hFF; a_sel = 2'($urandom);
        cyc();
        checks++;
        if (a_y !== 2'b01) begin
            failures++;
            $display("FAIL disable_ch1 got=%b exp=01", a_y);
        end
        a_en = 2'b00;
    endtask

    task automatic test_small();
        b_mode = 2'd1; b_ld = 1'b1; b_sel = 2'd2; b_adv = 1'b0;
        b_en = 4'h0; b_data = 12'h5A3;
        cyc();
        b_ld = 1'b0; b_adv = 1'b1;
        cyc();
        checks++;
        if ({b_selq, b_wrap} !== {2'd0, 1'b1}) begin
            failures++;
            $display("FAIL small_wrap got=%0d/%b exp=0/1",
                     b_selq, b_wrap);
        end
        b_mode = 2'd0; b_sel = 2'd3; b_adv = 1'b0;
        b_data = 12'b001_000_001_001;
        cyc();
        checks++;
        if ({b_y, b_selq} !== {4'b1011, 2'd0}) begin
            failures++;
            $display("FAIL small_clamp got=%b/%0d exp=1011/0",
                     b_y, b_selq);
        end
        b_mode = 2'd3; b_adv = 1'b1; b_data = 12'hFFF;
        cyc();
        b_adv = 1'b0;
        cyc();
        rb = 1'b1;
        cyc();
        checks++;
        if (got_b() !== 9'h000) begin
            failures++;
            $display("FAIL small_rst_os got=%h exp=000", got_b());
        end
        rb = 1'b0;
        cyc();
        checks++;
        if (got_b() !== 9'h000) begin
            failures++;
            $display("FAIL small_idle got=%h exp=000", got_b());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            ra = ($urandom_range(0, 59) == 0);
            rb = ($urandom_range(0, 59) == 0);
            a_mode = 2'($urandom); b_mode = 2'($urandom);
            a_sel = 2'($urandom); b_sel = 2'($urandom);
            a_ld = ($urandom_range(0, 3) == 0);
            b_ld = ($urandom_range(0, 3) == 0);
            a_adv = ($urandom_range(0, 2) == 0);
            b_adv = ($urandom_range(0, 2) == 0);
            a_en = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            b_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            a_data = 8'($urandom); b_data = 12'($urandom);
            // Keep one-shot running long enough to finish passes
            if (i % 40 < 12) begin
                a_mode = 2'd3; b_mode = 2'd3;
            end
            cyc();
            checks++;
            if (got_a() !== exp_vec(ma)) begin
                failures++;
                $display("FAIL rand_a cyc=%0d got=%h exp=%h",
                         i, got_a(), exp_vec(ma));
            end
            checks++;
            if (got_b() !== exp_vec(mb)) begin
                failures++;
                $display("FAIL rand_b cyc=%0d got=%h exp=%h",
                         i, got_b(), exp_vec(mb));
            end
        end
        ra = 1'b0; rb = 1'b0;
    endtask

    initial begin
        ma = '{0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        mb = ma;
        #2;
        test_reset();
        test_direct();
        test_scan();
        test_oneshot();
        test_hold();
        test_small();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
